// File: rtl/bridge_pkg.sv
// Shared constants and helpers for the host bridge (receive and transmit paths).
package bridge_pkg;

    localparam logic [7:0] PREAMBLE = 8'h4D;  // 'M'
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] LF       = 8'h0A;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Uppercase hex digit for one nibble: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational nibble-to-ASCII encoder, a thin wrapper around the package function.
module nibble_to_ascii
    import bridge_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = hex_to_ascii(nibble);

endmodule

// File: rtl/bridge_tx.sv
// Bridge return path: serialises bus read responses as 'M' + hex digits + CR LF
// towards uart_tx, with a one-entry pending slot for responses arriving mid-frame.
module bridge_tx
    import bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 16
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  busy_o,
    output logic                  overflow_o
);

    localparam int NIB   = DATA_WIDTH / 4;
    localparam int IDX_W = $clog2(NIB + 3);

    localparam logic [IDX_W-1:0] IDX_LAST_DIGIT = IDX_W'(NIB);
    localparam logic [IDX_W-1:0] IDX_CR         = IDX_W'(NIB + 1);
    localparam logic [IDX_W-1:0] IDX_LF         = IDX_W'(NIB + 2);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  pend_full_q, pend_full_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            digit;
    logic [7:0]            cur_byte;
    logic                  read_req;
    logic                  accept;
    logic                  last_byte;

    assign read_req  = valid_i && !rw_i;
    assign accept    = tx_valid_o && tx_ready_i;
    assign last_byte = (idx_q == IDX_LF);

    // The top nibble of the shift register is always the next digit to send.
    nibble_to_ascii u_enc (
        .nibble (shreg_q[DATA_WIDTH-1 -: 4]),
        .ascii  (digit)
    );

    // Select the byte for the current frame position.
    always_comb begin
        if (idx_q == '0) begin
            cur_byte = PREAMBLE;
        end else if (idx_q == IDX_CR) begin
            cur_byte = CR;
        end else if (last_byte) begin
            cur_byte = LF;
        end else begin
            cur_byte = digit;
        end
    end

    assign tx_valid_o = (state_q == SEND);
    assign tx_data_o  = (state_q == SEND) ? cur_byte : 8'h00;
    assign busy_o     = (state_q == SEND) || pend_full_q;
    assign overflow_o = ovf_q;

    // Next-state, frame sequencing and pending-slot bookkeeping.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        pend_data_d = pend_data_q;
        pend_full_d = pend_full_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (read_req) begin
                    shreg_d = rdata_i;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end

            SEND: begin
                // A response arriving mid-frame parks in the slot; on the LF
                // handshake an empty slot is bypassed and the frame starts directly.
                if (read_req) begin
                    if (pend_full_q) begin
                        ovf_d = 1'b1;
                    end else if (!(accept && last_byte)) begin
                        pend_full_d = 1'b1;
                        pend_data_d = rdata_i;
                    end
                end

                if (accept) begin
                    if (last_byte) begin
                        idx_d = '0;
                        if (pend_full_q) begin
                            shreg_d     = pend_data_q;
                            pend_full_d = 1'b0;
                        end else if (read_req) begin
                            shreg_d = rdata_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (idx_q != '0 && idx_q <= IDX_LAST_DIGIT) begin
                            shreg_d = shreg_q << 4;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state: reset abandons any partial frame and the pending slot.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pend_full_q <= pend_full_d;
            ovf_q       <= ovf_d;
        end
    end

    // Payload registers.
    always_ff @(posedge clk) begin
        // NOTE: payload needs no reset; it is always loaded before its valid flag is set.
        shreg_q     <= shreg_d;
        pend_data_q <= pend_data_d;
    end

endmodule

// File: tb/tb_bridge_tx.sv
// Self-checking bench for bridge_tx: directed and randomised reads checked against
// a frame-level reference model (expected byte stream plus outstanding-frame count).
module tb_bridge_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] rdata_i;
    logic        rw_i;
    logic        valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic        overflow_o;

    bridge_tx #(.DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdata_i    (rdata_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bytes still owed to the UART, frames accepted but not finished
    // (at most one in flight plus one waiting), and the sticky overflow flag.
    logic [7:0] exp_q[$];
    int         outstanding = 0;
    bit         ovf_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input int v);
        return (v < 10) ? 8'(48 + v) : 8'(65 + v - 10);   // '0'.. / 'A'..
    endfunction

    function automatic void push_frame(input logic [15:0] d);
        exp_q.push_back(8'h4D);
        for (int i = 3; i >= 0; i--) begin
            exp_q.push_back(hex_char(int'((d >> (4 * i)) & 16'hF)));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        outstanding = 0;
        ovf_exp     = 1'b0;
    endfunction

    // One clock cycle, entered and left at a falling edge: compare outputs against the
    // model, drive inputs for the coming rising edge, then advance the model.
    task automatic cyc(input bit v, input bit rw, input logic [15:0] d, input bit rdy);
        bit hs;
        bit lf;
        check("tx_valid", 32'(tx_valid_o), 32'(exp_q.size() > 0));
        check("tx_data", 32'(tx_data_o), 32'((exp_q.size() > 0) ? exp_q[0] : 8'h00));
        check("busy", 32'(busy_o), 32'(outstanding > 0));
        check("overflow", 32'(overflow_o), 32'(ovf_exp));
        valid_i    = v;
        rw_i       = rw;
        rdata_i    = d;
        tx_ready_i = rdy;
        hs = (exp_q.size() > 0) && rdy;
        lf = hs && (exp_q[0] == 8'h0A);
        if (v && !rw) begin
            if (outstanding < 2) begin
                push_frame(d);
                outstanding++;
            end else begin
                ovf_exp = 1'b1;
            end
        end
        if (hs) void'(exp_q.pop_front());
        if (lf) outstanding--;
        @(negedge clk);
    endtask

    task automatic drain(input int ready_pct);
        int n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            cyc(1'b0, 1'b0, 16'h0, $urandom_range(0, 99) < ready_pct);
            n++;
        end
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 32'(tx_valid_o), 32'h0);
        check({tag, "_tx_data"}, 32'(tx_data_o), 32'h0);
        check({tag, "_busy"}, 32'(busy_o), 32'h0);
        check({tag, "_overflow"}, 32'(overflow_o), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        valid_i    = 1'b0;
        rw_i       = 1'b0;
        rdata_i    = '0;
        tx_ready_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frames with the UART always ready.
        cyc(1'b1, 1'b0, 16'h1234, 1'b1);
        drain(100);
        cyc(1'b1, 1'b0, 16'hBEEF, 1'b1);
        drain(100);
        cyc(1'b1, 1'b0, 16'h0000, 1'b1);
        drain(100);

        // Write completion produces nothing.
        cyc(1'b1, 1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1);

        // New read exactly on the LF handshake: next frame follows with no gap.
        cyc(1'b1, 1'b0, 16'h9F3C, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b0, 16'h7A61, 1'b1);
        drain(100);

        // Randomised data with ~30% ready; reads only while the slot can take them.
        for (int i = 0; i < 300; i++) begin
            cyc((outstanding < 2) && ($urandom_range(0, 9) == 0), 1'b0,
                16'($urandom), $urandom_range(0, 99) < 30);
        end
        drain(30);

        // A, B two cycles later into the slot, C while the slot is full -> dropped.
        cyc(1'b1, 1'b0, 16'h00AB, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b0, 16'hC0DE, 1'b1);
        cyc(1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b0, 16'h1111, 1'b1);
        drain(100);

        // Reset in the middle of a frame, after three bytes have gone out.
        cyc(1'b1, 1'b0, 16'h5A5A, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        model_reset();
        @(negedge clk);
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 16'h0001, 1'b1);
        drain(100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
